inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-issue instruction queue between fetch and decode.
- Each cycle it accepts one 64-bit fetch word, which holds two 32-bit instructions.
- Each cycle it presents the two oldest instructions to decode; decode retires 0, 1 or 2 of them.
- Provides full/empty flow control and a pipeline flush for redirects.

Parameters:
- DEPTH, 64, entries (32-bit instructions); power of two, minimum 4.
- IW, 32, instruction width in bits.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all queued instructions (branch redirect).
- enq_valid  in  1  fetch word present.
- enq_ready  out  1  queue has at least 2 free entries.
- enq_data  in  [0:63]  fetch word; [0:31] is the older instruction, [32:63] the younger.
- deq_inst0  out  [0:IW-1]  oldest instruction (entry at head).
- deq_inst1  out  [0:IW-1]  second-oldest instruction (entry at head+1).
- deq_valid0  out  1  count >= 1.
- deq_valid1  out  1  count >= 2.
- deq_pair_ok  out  1  inst0 and inst1 may issue together.
- deq_count  in  [0:1]  number retired this cycle: 0, 1 or 2 (3 is illegal).
- count  out  [0:log2(DEPTH)]  current occupancy.

Behaviour:
- Storage: DEPTH x IW array.
- Pointers: head and tail, each log2(DEPTH)+1 bits. Index is the low bits; the extra MSB distinguishes full from empty.
- count = tail - head, computed modulo 2^(log2(DEPTH)+1).
- Reset (async, rst_n=0): head=0, tail=0, count=0, deq_valid0=0, deq_valid1=0, deq_pair_ok=0, deq_inst0=0, deq_inst1=0, enq_ready=1.
- Array contents are not reset. Any output reading a slot beyond count is forced to 0.
- Enqueue fires when enq_valid && enq_ready:
  - mem[tail] = enq_data[0:31]
  - mem[tail+1] = enq_data[32:63]
  - tail += 2
- enq_ready = (DEPTH - count) >= 2, computed from the registered count only. There is no same-cycle credit from a dequeue.
- Dequeue: head += effective_deq, where effective_deq = min(deq_count, count).
  - Over-request is clamped.
  - Under simulation it fires an error assertion.
- Output timing:
  - Outputs are combinational from registered state (array at head/head+1 plus count).
  - Enqueue-to-visible latency is 1 cycle: an enqueue into an empty queue shows deq_valid0=1 the following cycle. There is no bypass.
- Simultaneous enqueue and dequeue are both applied; next count = count + 2*enq - effective_deq.
- Flush has priority over everything:
  - Next cycle head=tail=0 and count=0.
  - A same-cycle enqueue is dropped; deq_count is ignored.
  - Outputs go to the reset values the next cycle.
- Wrap-around: index arithmetic is modulo DEPTH. A pair may straddle the last/first slot; a pair with tail at DEPTH-1 splits across index DEPTH-1 and index 0.
- Full: count=DEPTH-1 or DEPTH gives enq_ready=0. Occupancy never exceeds DEPTH.
- Empty: count=0 gives both valids 0; deq_count is clamped to 0.

Optional Feature:
- Macro: INST_QUEUE_PAIR_CHECK_EN.
- With the macro defined, deq_pair_ok = deq_valid1 && no RAW hazard, where:
  - inst0 RT is bits [6:10].
  - inst1 RA is bits [11:15]; inst1 RB is bits [16:20].
  - A hazard exists if RT0 equals RA1 or RB1.
  - A hazard also exists if inst0 is a branch (primary opcode [0:5] in {16, 18, 19}).
- Without the macro: deq_pair_ok = deq_valid1.

Decomposition:
- Package ppc_pkg:
  - IW
  - opcode field constants: OPC_LO=0, OPC_HI=5, RT_LO=6, RT_HI=10, RA_LO=11, RA_HI=15, RB_LO=16, RB_HI=20
  - branch opcode constants: OP_B=18, OP_BC=16, OP_XL=19
  - typedef inst_t [0:31]
- Sub-module inst_pair_check (combinational hazard check). It is instantiated only under INST_QUEUE_PAIR_CHECK_EN.

Test Plan:
1. Reset, then enqueue 0x38210001_38420002 with no dequeue.
   - Next cycle: count=2, inst0=0x38210001, inst1=0x38420002, both valid.
2. Fill test: enqueue with deq_count=0 for 32 cycles (DEPTH=64).
   - enq_ready drops at count=64.
   - A further enq_valid is ignored; count stays 64.
3. Wrap-around: cycle head/tail near DEPTH-1 with deq_count=1 alternating 2.
   - Order is preserved and each instruction is seen exactly once (compare against a scoreboard).
4. Flush with enq_valid=1 and deq_count=2 at count=10.
   - Next cycle: count=0, valids 0, enq_ready=1.
5. deq_count=2 at count=1.
   - Clamped: count=0 and the assertion fires.
6. With INST_QUEUE_PAIR_CHECK_EN defined:
   - Pair 0x7C632214 (add r3,r3,r4) then 0x7CA31A14 (add r5,r3,r3) gives pair_ok=0.
   - Pair 0x7C632214 then 0x7CA42214 (add r5,r4,r4) gives pair_ok=1.

Source files
------------

// File: rtl/ppc_pkg.sv
// -----------------------------------------------------------------------------
// ppc_pkg
// Shared definitions for the instruction queue and its pair checker.
// Fields use big-endian bit numbering (bit 0 is the MSB), matching the
// instruction-set documentation, so field constants can be used directly as
// slice bounds on inst_t.
//   IW                  instruction width in bits
//   OPC_*/RT_*/RA_*/RB_* field bounds within an instruction
//   OP_B/OP_BC/OP_XL    primary opcodes of the branch family
//   inst_t              one instruction, bits [0:31]
//   is_branch()         true when a primary opcode belongs to the branch family
// -----------------------------------------------------------------------------
package ppc_pkg;

  localparam int IW = 32;

  // Field bounds (big-endian bit numbers)
  localparam int OPC_LO = 0;
  localparam int OPC_HI = 5;
  localparam int RT_LO  = 6;
  localparam int RT_HI  = 10;
  localparam int RA_LO  = 11;
  localparam int RA_HI  = 15;
  localparam int RB_LO  = 16;
  localparam int RB_HI  = 20;

  // Branch-family primary opcodes
  localparam logic [0:5] OP_BC = 6'd16;
  localparam logic [0:5] OP_B  = 6'd18;
  localparam logic [0:5] OP_XL = 6'd19;

  typedef logic [0:IW-1] inst_t;

  function automatic logic is_branch(input logic [0:5] opc);
    return (opc == OP_B) || (opc == OP_BC) || (opc == OP_XL);
  endfunction

endpackage : ppc_pkg

// File: rtl/inst_pair_check.sv
// -----------------------------------------------------------------------------
// inst_pair_check
// Combinational dual-issue hazard check for two adjacent instructions.
// Only instantiated by inst_queue when INST_QUEUE_PAIR_CHECK_EN is defined.
//   inst0_i   older instruction
//   inst1_i   younger instruction
//   hazard_o  1 when the pair must not issue together: inst1 reads the
//             register that inst0 writes (RT0 == RA1 or RT0 == RB1), or inst0
//             is a branch
// -----------------------------------------------------------------------------
module inst_pair_check
  import ppc_pkg::*;
(
  input  inst_t inst0_i,
  input  inst_t inst1_i,
  output logic  hazard_o
);

  logic [0:5] opc0;
  logic [0:4] rt0;
  logic [0:4] ra1;
  logic [0:4] rb1;
  logic       raw_hit;
  logic       branch0;

  assign opc0 = inst0_i[OPC_LO:OPC_HI];
  assign rt0  = inst0_i[RT_LO:RT_HI];
  assign ra1  = inst1_i[RA_LO:RA_HI];
  assign rb1  = inst1_i[RB_LO:RB_HI];

  // The check is conservative: it compares fields regardless of instruction
  // form, so a false hazard only costs a single-issue cycle.
  assign raw_hit  = (rt0 == ra1) || (rt0 == rb1);
  assign branch0  = is_branch(opc0);
  assign hazard_o = raw_hit || branch0;

  // Fields that play no part in the check
  logic unused_bits;
  assign unused_bits = ^{inst0_i[RA_LO:IW-1], inst1_i[OPC_LO:RT_HI], inst1_i[RB_HI+1:IW-1]};

endmodule : inst_pair_check

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Dual-issue instruction queue between fetch and decode. Accepts one 64-bit
// fetch word (two instructions) per cycle and presents the two oldest
// instructions to decode, which retires 0, 1 or 2 of them per cycle.
//
// Parameters
//   DEPTH  number of 32-bit entries, power of two, >= 4
//   IW     instruction width in bits
//
// Ports
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        discard all queued instructions (priority over everything)
//   enq_valid    fetch word present
//   enq_ready    at least two free entries (from registered occupancy only)
//   enq_data     fetch word, [0:31] older instruction, [32:63] younger
//   deq_inst0    oldest instruction, 0 when count < 1
//   deq_inst1    second-oldest instruction, 0 when count < 2
//   deq_valid0   count >= 1
//   deq_valid1   count >= 2
//   deq_pair_ok  inst0 and inst1 may issue together
//   deq_count    instructions retired this cycle (0..2; 3 is illegal)
//   count        current occupancy
//
// Build options
//   INST_QUEUE_PAIR_CHECK_EN  when defined, deq_pair_ok additionally requires
//                             no RAW/branch hazard between inst0 and inst1
//                             (inst_pair_check); otherwise it equals deq_valid1
//   INST_QUEUE_DEQ_ASSERT_EN  when defined, simulation flags any retire
//                             request larger than the occupancy as an error
// -----------------------------------------------------------------------------
module inst_queue
  import ppc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = ppc_pkg::IW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [0:63]            enq_data,
  output logic [0:IW-1]          deq_inst0,
  output logic [0:IW-1]          deq_inst1,
  output logic                   deq_valid0,
  output logic                   deq_valid1,
  output logic                   deq_pair_ok,
  input  logic [0:1]             deq_count,
  output logic [0:$clog2(DEPTH)] count
);

  localparam int AW = $clog2(DEPTH);  // index width
  localparam int PW = AW + 1;         // pointer width, MSB separates full/empty

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [0:IW-1] mem_q [DEPTH];

  logic [PW-1:0] count_w;
  logic [AW-1:0] tail_idx;
  logic [AW-1:0] tail_idx1;
  logic          enq_fire;
  logic          deq_overreq;
  logic [1:0]    deq_req;
  logic [1:0]    deq_eff;

  // Modulo-2^PW subtraction gives the occupancy including the full case.
  assign count_w = tail_q - head_q;
  assign count   = count_w;

  // Registered occupancy only: a same-cycle retire does not free space.
  assign enq_ready = (count_w <= PW'(DEPTH - 2));
  assign enq_fire  = enq_valid && enq_ready && !flush;

  // ---------------------------------------------------------------------------
  // Retire clamping
  // ---------------------------------------------------------------------------
  // Only two instructions are ever presented, so an illegal request of 3 is
  // treated as 2; anything beyond the occupancy is trimmed to the occupancy.
  assign deq_req     = (deq_count == 2'd3) ? 2'd2 : deq_count;
  assign deq_overreq = (PW'(deq_count) > count_w);
  // When over-requesting, count_w < deq_count <= 3, so its low bits hold it.
  assign deq_eff     = deq_overreq ? count_w[1:0] : deq_req;

  // ---------------------------------------------------------------------------
  // Pointer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q + PW'(deq_eff);
    tail_d = tail_q;
    if (enq_fire) begin
      tail_d = tail_q + PW'(2);
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: two writes per accepted fetch word; contents are never reset.
  // ---------------------------------------------------------------------------
  // The index adder wraps naturally, so a pair may straddle DEPTH-1 and 0.
  assign tail_idx  = tail_q[AW-1:0];
  assign tail_idx1 = tail_idx + AW'(1);

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_q[tail_idx]  <= enq_data[0:IW-1];
      mem_q[tail_idx1] <= enq_data[IW:2*IW-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: slot gi sits at head+gi and is valid while count > gi.
  // Slots beyond the occupancy read as 0 so stale array data never leaks out.
  // ---------------------------------------------------------------------------
  logic [0:IW-1] rd_inst  [2];
  logic          rd_valid [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0] slot_idx;
    assign slot_idx     = head_q[AW-1:0] + AW'(gi);
    assign rd_valid[gi] = (count_w > PW'(gi));
    assign rd_inst[gi]  = rd_valid[gi] ? mem_q[slot_idx] : '0;
  end

  assign deq_valid0 = rd_valid[0];
  assign deq_valid1 = rd_valid[1];
  assign deq_inst0  = rd_inst[0];
  assign deq_inst1  = rd_inst[1];

  // ---------------------------------------------------------------------------
  // Pair issue permission
  // ---------------------------------------------------------------------------
`ifdef INST_QUEUE_PAIR_CHECK_EN
  logic pair_hazard;

  inst_pair_check u_pair_check (
    .inst0_i  (rd_inst[0]),
    .inst1_i  (rd_inst[1]),
    .hazard_o (pair_hazard)
  );

  assign deq_pair_ok = deq_valid1 && !pair_hazard;
`else
  assign deq_pair_ok = deq_valid1;
`endif

  // ---------------------------------------------------------------------------
  // Retire over-request check (clamped above; flagged here as a decode bug)
  // ---------------------------------------------------------------------------
`ifdef INST_QUEUE_DEQ_ASSERT_EN
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!deq_overreq)
        else $error("inst_queue: deq_count %0d exceeds occupancy %0d", deq_count, count_w);
    end
  end
`endif

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  localparam int DEPTH = 64;
  localparam int IW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  logic [0:63]   enq_data = '0;
  logic [0:1]    deq_count = '0;
  logic          enq_ready;
  logic [0:IW-1] deq_inst0;
  logic [0:IW-1] deq_inst1;
  logic          deq_valid0;
  logic          deq_valid1;
  logic          deq_pair_ok;
  logic [0:6]    count;

  inst_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_data    (enq_data),
    .deq_inst0   (deq_inst0),
    .deq_inst1   (deq_inst1),
    .deq_valid0  (deq_valid0),
    .deq_valid1  (deq_valid1),
    .deq_pair_ok (deq_pair_ok),
    .deq_count   (deq_count),
    .count       (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          txn      = 0;
  logic [31:0] seq_val  = 32'h1000_0000;
  logic [31:0] sb [$];   // expected queue contents, oldest first

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference hazard rule; a, b use numeric bit order (bit 31 = ISA bit 0).
  function automatic logic ref_hazard(input logic [31:0] a, input logic [31:0] b);
    logic [5:0] opc;
    logic [4:0] rt;
    opc = a[31:26];
    rt  = a[25:21];
    return (rt == b[20:16]) || (rt == b[15:11]) ||
           (opc == 6'd16) || (opc == 6'd18) || (opc == 6'd19);
  endfunction

  task automatic check_outputs(input string ph);
    int          n;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ep;
    n  = sb.size();
    e0 = (n >= 1) ? sb[0] : 32'h0;
    e1 = (n >= 2) ? sb[1] : 32'h0;
    ep = (n >= 2);
`ifdef INST_QUEUE_PAIR_CHECK_EN
    if (ep) ep = !ref_hazard(e0, e1);
`endif
    expect_eq({ph, "count"},   64'(count),      64'(n));
    expect_eq({ph, "valid0"},  64'(deq_valid0), 64'(n >= 1));
    expect_eq({ph, "valid1"},  64'(deq_valid1), 64'(n >= 2));
    expect_eq({ph, "inst0"},   64'(deq_inst0),  64'(e0));
    expect_eq({ph, "inst1"},   64'(deq_inst1),  64'(e1));
    expect_eq({ph, "ready"},   64'(enq_ready),  64'(n <= DEPTH - 2));
    expect_eq({ph, "pair_ok"}, 64'(deq_pair_ok), 64'(ep));
  endtask

  // One transaction: check current outputs, drive inputs, update the model,
  // advance one clock.
  task automatic step(input logic ev, input logic [63:0] d, input logic [1:0] dc,
                      input logic fl, input string ph);
    int   n;
    int   take;
    logic fire;
    check_outputs(ph);
    enq_valid = ev;
    enq_data  = d;
    deq_count = dc;
    flush     = fl;
    #1;
    n    = sb.size();
    fire = ev && (n <= DEPTH - 2);
    expect_eq({ph, "overreq"}, 64'(dut.deq_overreq), 64'(int'(dc) > n));
    $display("txn %0d %s enq=%0b data=%h deq=%0d flush=%0b count=%0d accepted=%0b",
             txn, ph, ev, d, dc, fl, n, fire && !fl);
    txn++;
    if (fl) begin
      sb.delete();
    end else begin
      take = (int'(dc) > n) ? n : int'(dc);
      repeat (take) void'(sb.pop_front());
      if (fire) begin
        sb.push_back(d[63:32]);
        sb.push_back(d[31:0]);
      end
    end
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_count = '0;
    flush     = 1'b0;
  endtask

  function automatic logic [63:0] next_word();
    logic [63:0] w;
    w = {seq_val, seq_val + 32'd1};
    seq_val = seq_val + 32'd2;
    return w;
  endfunction

  initial begin
    logic [1:0] dc;
    logic       ev;
    logic       exp_pair;

    // Reset state
    #12;
    check_outputs("rst_");
    rst_n = 1'b1;

    // 1: single enqueue visible one cycle later
    step(1'b1, 64'h38210001_38420002, 2'd0, 1'b0, "t1_");
    expect_eq("t1_count", 64'(count), 64'd2);
    expect_eq("t1_inst0", 64'(deq_inst0), 64'h38210001);
    expect_eq("t1_inst1", 64'(deq_inst1), 64'h38420002);

    // 2: fill from empty
    step(1'b0, 64'h0, 2'd0, 1'b1, "fl_");
    for (int i = 0; i < 32; i++) step(1'b1, next_word(), 2'd0, 1'b0, "fill_");
    expect_eq("t2_count_full", 64'(count), 64'd64);
    expect_eq("t2_ready_full", 64'(enq_ready), 64'd0);
    step(1'b1, next_word(), 2'd0, 1'b0, "over_");
    expect_eq("t2_count_hold", 64'(count), 64'd64);

    // 3: drain near the end, then cycle through wrap-around
    repeat (30) step(1'b0, 64'h0, 2'd2, 1'b0, "drain_");
    for (int i = 0; i < 200; i++) begin
      dc = (i % 2 == 0) ? 2'd1 : 2'd2;
      step(1'b1, next_word(), dc, 1'b0, "wrap_");
    end
    for (int i = 0; i < 150; i++) begin
      ev = 1'($urandom_range(0, 1));
      dc = 2'($urandom_range(0, 2));
      step(ev, next_word(), dc, 1'b0, "rand_");
    end

    // 4: flush wins over same-cycle enqueue and retire
    step(1'b0, 64'h0, 2'd0, 1'b1, "fl_");
    repeat (5) step(1'b1, next_word(), 2'd0, 1'b0, "t4_");
    expect_eq("t4_count10", 64'(count), 64'd10);
    step(1'b1, next_word(), 2'd2, 1'b1, "t4fl_");
    expect_eq("t4_count0", 64'(count), 64'd0);
    expect_eq("t4_valid0", 64'(deq_valid0), 64'd0);
    expect_eq("t4_valid1", 64'(deq_valid1), 64'd0);
    expect_eq("t4_ready",  64'(enq_ready), 64'd1);

    // 5: over-request at count=1 is clamped
    step(1'b1, next_word(), 2'd0, 1'b0, "t5_");
    step(1'b0, 64'h0, 2'd1, 1'b0, "t5_");
    expect_eq("t5_count1", 64'(count), 64'd1);
    step(1'b0, 64'h0, 2'd2, 1'b0, "t5clamp_");
    expect_eq("t5_count0", 64'(count), 64'd0);

    // 6: pair issue permission
`ifdef INST_QUEUE_PAIR_CHECK_EN
    exp_pair = 1'b0;
`else
    exp_pair = 1'b1;
`endif
    step(1'b1, 64'h7C632214_7CA31A14, 2'd0, 1'b0, "t6_");
    expect_eq("t6_raw_pair", 64'(deq_pair_ok), 64'(exp_pair));
    step(1'b0, 64'h0, 2'd2, 1'b0, "t6_");
    step(1'b1, 64'h7C632214_7CA42214, 2'd0, 1'b0, "t6_");
    expect_eq("t6_indep_pair", 64'(deq_pair_ok), 64'd1);
    step(1'b0, 64'h0, 2'd2, 1'b0, "t6_");
    step(1'b1, 64'h48000010_7C000214, 2'd0, 1'b0, "t6_");
    expect_eq("t6_branch_pair", 64'(deq_pair_ok), 64'(exp_pair));
    check_outputs("end_");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_queue
